// File: rtl/sigmoid_inverse_search.sv
// Inverse sigmoid lookup: binary search over the monotonic sigmoid table
// for the largest entry <= target, returning its signed (floor logit) index.
//
// Ports:
//   clk, rst_n           rising-edge clock, async active-low reset
//   start, target        one-cycle request and IEEE-754 double probability
//   busy, done           search in progress / one-cycle result strobe
//   result, underflow    signed index (sign-extended) and below-table flag
//   rom_rd_en, rom_addr  table read strobe and address
//   rom_data             table word, valid one cycle after rom_rd_en
module sigmoid_inverse_search #(
    parameter int DEPTH  = 500,
    parameter int OFFSET = 250,
    parameter int AW     = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [63:0]   target,
    output logic          busy,
    output logic          done,
    output logic [63:0]   result,
    output logic          underflow,
    output logic          rom_rd_en,
    output logic [AW-1:0] rom_addr,
    input  logic [63:0]   rom_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        CMP0,
        RD,
        CMP,
        FIN
    } state_t;

    localparam logic [AW-1:0] TOP  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] MID0 = AW'(DEPTH / 2);

    state_t        state;
    logic [63:0]   tgt;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic [AW-1:0] mid;

    // Non-negative doubles order the same as their raw bit patterns.
    logic          le;
    logic [AW-1:0] nlo;
    logic [AW-1:0] nhi;
    logic [AW:0]   sum;
    logic [AW-1:0] nmid;

    assign le = (rom_data <= tgt);

    // Next search bounds after a CMP, and the upper-biased midpoint
    // of that interval (extra bit keeps lo+hi+1 from wrapping).
    always_comb begin
        nlo = lo;
        nhi = hi;
        if (le) begin
            nlo = mid;
        end else begin
            nhi = mid - AW'(1);
        end
        sum  = {1'b0, nlo} + {1'b0, nhi} + (AW+1)'(1);
        nmid = AW'(sum >> 1);
    end

    function automatic logic [63:0] to_index(input logic [AW-1:0] v);
        return 64'(v) - 64'(OFFSET);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tgt       <= '0;
            lo        <= '0;
            hi        <= '0;
            mid       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            underflow <= 1'b0;
            rom_rd_en <= 1'b0;
            rom_addr  <= '0;
        end else begin
            done      <= 1'b0;
            rom_rd_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tgt  <= target;
                        busy <= 1'b1;
                        if (target[63]) begin
                            lo        <= '0;
                            result    <= to_index('0);
                            underflow <= 1'b1;
                            done      <= 1'b1;
                            state     <= FIN;
                        end else begin
                            rom_rd_en <= 1'b1;
                            rom_addr  <= '0;
                            state     <= RD0;
                        end
                    end
                end
                RD0: begin
                    state <= CMP0;
                end
                CMP0: begin
                    lo <= '0;
                    if (!le) begin
                        result    <= to_index('0);
                        underflow <= 1'b1;
                        done      <= 1'b1;
                        state     <= FIN;
                    end else if (TOP != '0) begin
                        hi        <= TOP;
                        mid       <= MID0;
                        rom_rd_en <= 1'b1;
                        rom_addr  <= MID0;
                        state     <= RD;
                    end else begin
                        hi        <= TOP;
                        result    <= to_index('0);
                        underflow <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
                RD: begin
                    state <= CMP;
                end
                CMP: begin
                    lo <= nlo;
                    hi <= nhi;
                    if (nlo < nhi) begin
                        mid       <= nmid;
                        rom_rd_en <= 1'b1;
                        rom_addr  <= nmid;
                        state     <= RD;
                    end else begin
                        result    <= to_index(nlo);
                        underflow <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
